// File: rtl/apb3_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb3_master_ctrl
// Description : Single-outstanding APB3 master with request/response handshake
//               and a wait-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_master_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              io_mainClk,
    input  logic              io_systemReset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] io_apb_PADDR,
    output logic              io_apb_PSEL,
    output logic              io_apb_PENABLE,
    output logic              io_apb_PWRITE,
    output logic [31:0]       io_apb_PWDATA,
    input  logic              io_apb_PREADY,
    input  logic [31:0]       io_apb_PRDATA,
    input  logic              io_apb_PSLVERROR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [15:0] c_TIMEOUT  = 16'(TIMEOUT);
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    state_t              r_state,     w_state_nx;
    logic                r_psel,      w_psel_nx;
    logic                r_penable,   w_penable_nx;
    logic [ADDR_W-1:0]   r_paddr,     w_paddr_nx;
    logic                r_pwrite,    w_pwrite_nx;
    logic [31:0]         r_pwdata,    w_pwdata_nx;
    logic                r_rsp_valid, w_rsp_valid_nx;
    logic [31:0]         r_rsp_rdata, w_rsp_rdata_nx;
    logic                r_rsp_err,   w_rsp_err_nx;
    logic                r_busy,      w_busy_nx;
    logic [15:0]         r_wait_cnt,  w_wait_cnt_nx;
    logic                w_req_ready;
    logic                w_timeout_hit;

    assign w_req_ready   = (r_state == ST_IDLE) && (!r_rsp_valid || rsp_ready);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == c_TIMEOUT);

    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_wait_cnt  <= 16'd0;
        end else begin
            r_state     <= w_state_nx;
            r_psel      <= w_psel_nx;
            r_penable   <= w_penable_nx;
            r_paddr     <= w_paddr_nx;
            r_pwrite    <= w_pwrite_nx;
            r_pwdata    <= w_pwdata_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_rdata <= w_rsp_rdata_nx;
            r_rsp_err   <= w_rsp_err_nx;
            r_busy      <= w_busy_nx;
            r_wait_cnt  <= w_wait_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_psel_nx      = r_psel;
        w_penable_nx   = r_penable;
        w_paddr_nx     = r_paddr;
        w_pwrite_nx    = r_pwrite;
        w_pwdata_nx    = r_pwdata;
        w_rsp_valid_nx = r_rsp_valid;
        w_rsp_rdata_nx = r_rsp_rdata;
        w_rsp_err_nx   = r_rsp_err;
        w_wait_cnt_nx  = r_wait_cnt;

        // A consumed response drops; a completion below may reload it on the same edge.
        if (r_rsp_valid && rsp_ready) begin
            w_rsp_valid_nx = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (req_valid && w_req_ready) begin
                    w_state_nx    = ST_SETUP;
                    w_psel_nx     = 1'b1;
                    w_penable_nx  = 1'b0;
                    w_paddr_nx    = req_addr;
                    w_pwrite_nx   = req_write;
                    w_pwdata_nx   = req_wdata;
                    w_wait_cnt_nx = 16'd0;
                end
            end
            ST_SETUP: begin
                w_state_nx   = ST_ACCESS;
                w_penable_nx = 1'b1;
            end
            ST_ACCESS: begin
                if (io_apb_PREADY) begin
                    w_state_nx     = ST_IDLE;
                    w_psel_nx      = 1'b0;
                    w_penable_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_rdata_nx = r_pwrite ? 32'd0 : io_apb_PRDATA;
                    w_rsp_err_nx   = io_apb_PSLVERROR;
                end else if (w_timeout_hit) begin
                    w_state_nx     = ST_IDLE;
                    w_psel_nx      = 1'b0;
                    w_penable_nx   = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_rdata_nx = 32'd0;
                    w_rsp_err_nx   = 1'b1;
                end else if (r_wait_cnt != c_CNT_MAX) begin
                    w_wait_cnt_nx = r_wait_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nx   = ST_IDLE;
                w_psel_nx    = 1'b0;
                w_penable_nx = 1'b0;
            end
        endcase

        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    assign req_ready      = w_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_err        = r_rsp_err;
    assign busy           = r_busy;
    assign io_apb_PADDR   = r_paddr;
    assign io_apb_PSEL    = r_psel;
    assign io_apb_PENABLE = r_penable;
    assign io_apb_PWRITE  = r_pwrite;
    assign io_apb_PWDATA  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb3_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_master_ctrl
// Description : Directed self-checking bench for apb3_master_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] pwdata, prdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    apb3_master_ctrl #(.ADDR_W(8), .TIMEOUT(4)) dut (
        .io_mainClk       (clk),
        .io_systemReset   (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .io_apb_PADDR     (paddr),
        .io_apb_PSEL      (psel),
        .io_apb_PENABLE   (penable),
        .io_apb_PWRITE    (pwrite),
        .io_apb_PWDATA    (pwdata),
        .io_apb_PREADY    (pready),
        .io_apb_PRDATA    (prdata),
        .io_apb_PSLVERROR (pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        step;
        chk("rsp_consumed", rsp_valid, 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
        req_wdata = 32'd0; rsp_ready = 1'b0; pready = 1'b0; prdata = 32'd0; pslverr = 1'b0;
        step; step;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);

        // Write accepted on the first clock after reset release; PREADY high already in SETUP
        rst = 1'b0;
        issue(1'b1, 8'h10, 32'h11223344);
        pready = 1'b1;
        #1 chk("wr_req_ready", req_ready, 1);
        step;
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_setup_paddr", paddr, 8'h10);
        chk("wr_setup_pwrite", pwrite, 1);
        chk("wr_setup_pwdata", pwdata, 32'h11223344);
        chk("wr_setup_busy", busy, 1);
        req_valid = 1'b0;
        step;
        chk("wr_access_psel", psel, 1);
        chk("wr_access_penable", penable, 1);
        chk("wr_access_paddr", paddr, 8'h10);
        chk("wr_access_rsp_valid", rsp_valid, 0);
        step;
        chk("wr_done_psel", psel, 0);
        chk("wr_done_penable", penable, 0);
        chk("wr_done_rsp_valid", rsp_valid, 1);
        chk("wr_done_rsp_err", rsp_err, 0);
        chk("wr_done_rsp_rdata", rsp_rdata, 0);
        chk("wr_done_busy", busy, 0);
        chk("wr_idle_paddr_hold", paddr, 8'h10);
        chk("wr_idle_pwdata_hold", pwdata, 32'h11223344);
        consume;

        // Read with three wait states
        issue(1'b0, 8'h04, 32'hFFFF0000);
        pready = 1'b0; prdata = 32'hBAD0BAD0;
        step;
        chk("rd_setup_psel", psel, 1);
        chk("rd_setup_penable", penable, 0);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("rd_access_psel", psel, 1);
            chk("rd_access_penable", penable, 1);
            chk("rd_access_paddr", paddr, 8'h04);
            chk("rd_access_pwrite", pwrite, 0);
            if (i == 3) begin
                pready = 1'b1; prdata = 32'h00000001;
            end
        end
        step;
        chk("rd_done_psel", psel, 0);
        chk("rd_done_rsp_valid", rsp_valid, 1);
        chk("rd_done_rsp_rdata", rsp_rdata, 32'h00000001);
        chk("rd_done_rsp_err", rsp_err, 0);
        pready = 1'b0;
        consume;

        // Timeout: PREADY stuck low, abort after counter reaches 4
        issue(1'b0, 8'h20, 32'd0);
        prdata = 32'hDEADBEEF;
        step;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("to_access_penable", penable, 1);
            chk("to_access_rsp_valid", rsp_valid, 0);
        end
        step;
        chk("to_psel", psel, 0);
        chk("to_penable", penable, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_busy", busy, 0);
        consume;

        // Slave error on a read still returns PRDATA
        issue(1'b0, 8'h08, 32'd0);
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
        step;
        req_valid = 1'b0;
        step;
        step;
        chk("slverr_rsp_valid", rsp_valid, 1);
        chk("slverr_rsp_err", rsp_err, 1);
        chk("slverr_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        pslverr = 1'b0;
        consume;

        // PREADY rises in the very cycle the timeout would fire
        issue(1'b0, 8'h30, 32'd0);
        pready = 1'b0; prdata = 32'h12345678;
        step;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("tie_access_penable", penable, 1);
            if (i == 4) pready = 1'b1;
        end
        step;
        chk("tie_rsp_valid", rsp_valid, 1);
        chk("tie_rsp_err", rsp_err, 0);
        chk("tie_rsp_rdata", rsp_rdata, 32'h12345678);

        // Response back-pressure, then back-to-back writes
        issue(1'b1, 8'h40, 32'h0BADF00D);
        #1 chk("bp_req_ready", req_ready, 0);
        step;
        chk("bp_psel", psel, 0);
        chk("bp_rsp_valid_hold", rsp_valid, 1);
        chk("bp_rsp_rdata_hold", rsp_rdata, 32'h12345678);
        rsp_ready = 1'b1;
        #1 chk("bp_release_req_ready", req_ready, 1);
        step;
        chk("b2b_setup1_psel", psel, 1);
        chk("b2b_setup1_paddr", paddr, 8'h40);
        chk("b2b_setup1_rsp_valid", rsp_valid, 0);
        req_addr = 8'h44;
        step;
        chk("b2b_access1_penable", penable, 1);
        chk("b2b_access1_paddr", paddr, 8'h40);
        step;
        chk("b2b_done1_psel", psel, 0);
        chk("b2b_done1_rsp_valid", rsp_valid, 1);
        chk("b2b_done1_req_ready", req_ready, 1);
        step;
        chk("b2b_setup2_psel", psel, 1);
        chk("b2b_setup2_penable", penable, 0);
        chk("b2b_setup2_paddr", paddr, 8'h44);
        chk("b2b_setup2_rsp_valid", rsp_valid, 0);
        req_valid = 1'b0;
        step;
        step;
        chk("b2b_done2_rsp_valid", rsp_valid, 1);
        step;
        chk("b2b_consumed", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of ACCESS
        issue(1'b0, 8'h50, 32'd0);
        pready = 1'b0;
        step;
        req_valid = 1'b0;
        step;
        chk("ar_pre_penable", penable, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_psel", psel, 0);
        chk("ar_penable", penable, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_paddr", paddr, 0);
        step;
        rst = 1'b0;
        issue(1'b1, 8'h60, 32'h00000055);
        pready = 1'b1;
        step;
        chk("ar_next_psel", psel, 1);
        chk("ar_next_paddr", paddr, 8'h60);
        req_valid = 1'b0;
        step;
        chk("ar_next_penable", penable, 1);
        step;
        chk("ar_next_rsp_valid", rsp_valid, 1);
        chk("ar_next_rsp_err", rsp_err, 0);
        chk("ar_next_rsp_rdata", rsp_rdata, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb3_master_ctrl.md
APB3_MASTER_CTRL -- requirements
Module: apb3_master_ctrl

Interface
REQ-001 SHALL use parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL use parameter TIMEOUT, default 255, maximum ACCESS wait cycles with PREADY low; 0 disables the timeout.
REQ-003 SHALL have port io_mainClk  in  1  sole clock, rising edge.
REQ-004 SHALL have port io_systemReset  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-005 SHALL have port req_valid  in  1  request offered.
REQ-006 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  ADDR_W  target byte address.
REQ-009 SHALL have port req_wdata  in  32  write data.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed.
REQ-012 SHALL have port rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-013 SHALL have port rsp_err  out  1  PSLVERROR seen or timeout.
REQ-014 SHALL have port busy  out  1  state not IDLE.
REQ-015 SHALL have ports io_apb_PADDR out ADDR_W, io_apb_PSEL out 1, io_apb_PENABLE out 1, io_apb_PWRITE out 1, io_apb_PWDATA out 32, io_apb_PREADY in 1, io_apb_PRDATA in 32, io_apb_PSLVERROR in 1.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered except req_ready.
REQ-017 SHALL assert req_ready = (state==IDLE) && (!rsp_valid || rsp_ready).
REQ-018 SHALL, on accept (cycle N), latch addr/write/wdata into PADDR/PWRITE/PWDATA and enter SETUP: PSEL=1, PENABLE=0 in cycle N+1.
REQ-019 SHALL enter ACCESS in cycle N+2: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable through SETUP and all of ACCESS.
REQ-020 SHALL sample PREADY, PRDATA, PSLVERROR only in ACCESS; PREADY=1 completes the transfer.
REQ-021 SHALL, on completion, return to IDLE with PSEL=PENABLE=0 and assert rsp_valid next cycle (N+3 for zero wait states), rsp_rdata=PRDATA for reads else 0, rsp_err=PSLVERROR.
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_err until rsp_valid && rsp_ready; clear rsp_valid that cycle unless a new response loads the same edge.
REQ-023 SHALL count ACCESS cycles with PREADY=0 in a 16-bit counter, cleared on entering SETUP.
REQ-024 SHALL, when TIMEOUT!=0 and the counter equals TIMEOUT with PREADY still 0, abort: PSEL=PENABLE=0, IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-025 SHALL give PREADY=1 priority over timeout in the same cycle (normal completion).
REQ-026 SHALL hold PADDR/PWRITE/PWDATA at their last values while IDLE.
REQ-027 SHALL never issue PENABLE=1 without PSEL=1, and never skip SETUP.
REQ-028 SHALL give back-to-back throughput of one transfer per 3 cycles when rsp_ready is held high and PREADY=1.
REQ-029 SHALL assert busy in SETUP and ACCESS only.

Reset
REQ-030 SHALL, on io_systemReset high, immediately force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, busy=0, including mid-transfer.
REQ-031 SHALL accept a request in the first clock after reset deassertion.

Verification
REQ-032 SHALL verify: write addr 0x10 data 0x11223344, PREADY=1 -> SETUP N+1, ACCESS N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-033 SHALL verify: read 0x04, PREADY low 3 ACCESS cycles then high with PRDATA=0x00000001 -> ACCESS lasts 4 cycles, rsp_rdata=1, signals stable throughout.
REQ-034 SHALL verify: TIMEOUT=4, PREADY stuck 0 -> abort after 4 wait cycles, rsp_err=1, rsp_rdata=0, PSEL falls.
REQ-035 SHALL verify: read with PSLVERROR=1 and PREADY=1 -> rsp_err=1, rsp_rdata=PRDATA; and PREADY=1 on timeout cycle -> rsp_err=0.
REQ-036 SHALL verify: rsp_ready held 0 after a response -> req_ready=0, rsp held; rsp_ready=1 -> new request accepted the same cycle.
REQ-037 SHALL verify: reset asserted during ACCESS -> PSEL/PENABLE/rsp_valid drop without waiting for a clock edge; next request after release completes normally.
